netwalk_flow_stats_reader: RTL

NETWALK_FLOW_STATS_READER -- requirements
Module: netwalk_flow_stats_reader

---
 rtl/netwalk_flow_stats_reader_if.sv | 32 +++
 rtl/netwalk_flow_stats_reader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/netwalk_flow_stats_reader_if.sv
// Bus bundle for the flow-stats reader: meter read port, export handshake and sweep control/status.
// master = the reader, slave = the meter table plus the export sink.
interface netwalk_flow_stats_reader_if #(
    parameter int TCAM_ADDR_WIDTH    = 6,
    parameter int METER_COUNTER_SIZE = 32
);
    logic                          glbl_program_en;
    logic                          stats_req;
    logic                          meter_read_en;
    logic [TCAM_ADDR_WIDTH-1:0]    meter_read_addr;
    logic [METER_COUNTER_SIZE-1:0] meter_read_data;
    logic                          stats_valid;
    logic                          stats_ready;
    logic [TCAM_ADDR_WIDTH-1:0]    stats_addr;
    logic [METER_COUNTER_SIZE-1:0] stats_count;
    logic                          stats_last;
    logic                          stats_busy;
    logic                          stats_done;
    logic [TCAM_ADDR_WIDTH:0]      stats_entry_count;

    modport master (
        input  glbl_program_en, stats_req, meter_read_data, stats_ready,
        output meter_read_en, meter_read_addr, stats_valid, stats_addr, stats_count,
               stats_last, stats_busy, stats_done, stats_entry_count
    );

    modport slave (
        output glbl_program_en, stats_req, meter_read_data, stats_ready,
        input  meter_read_en, meter_read_addr, stats_valid, stats_addr, stats_count,
               stats_last, stats_busy, stats_done, stats_entry_count
    );
endinterface

// File: rtl/netwalk_flow_stats_reader.sv
// Sweeps the meter counter table on request and exports each (addr, count) over a valid/ready handshake.
// Optional macro STATS_SKIP_ZERO_EN: zero counters are skipped instead of exported.
//
// state | meaning
// IDLE  | waiting for stats_req
// READ  | strobing the meter read port at addr (holds while glbl_program_en)
// OUT   | presenting the snapshot until the sink accepts it
// DONE  | one-cycle completion pulse
module netwalk_flow_stats_reader #(
    parameter int TCAM_ADDR_WIDTH    = 6,
    parameter int METER_COUNTER_SIZE = 32
) (
    input logic clk,
    input logic reset,
    netwalk_flow_stats_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [TCAM_ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                          state, state_nxt;
    logic [TCAM_ADDR_WIDTH-1:0]      addr;
    logic [TCAM_ADDR_WIDTH-1:0]      stats_addr_q;
    logic [METER_COUNTER_SIZE-1:0]   stats_count_q;
    logic [TCAM_ADDR_WIDTH:0]        entry_count;

    logic sweep_start;
    logic read_fire;
    logic addr_adv;
    logic entry_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sweep_start = 1'b0;
        read_fire   = 1'b0;
        addr_adv    = 1'b0;
        entry_taken = 1'b0;
        case (state)
            IDLE: begin
                if (bus.stats_req) begin
                    sweep_start = 1'b1;
                    state_nxt   = READ;
                end
            end
            READ: begin
                if (!bus.glbl_program_en) begin
                    read_fire = 1'b1;
`ifdef STATS_SKIP_ZERO_EN
                    // Empty counters never reach the sink; the sweep just moves on.
                    if (bus.meter_read_data == '0) begin
                        if (addr == ADDR_MAX) begin
                            state_nxt = DONE;
                        end else begin
                            addr_adv = 1'b1;
                        end
                    end else begin
                        state_nxt = OUT;
                    end
`else
                    state_nxt = OUT;
`endif
                end
            end
            OUT: begin
                if (bus.stats_ready) begin
                    entry_taken = 1'b1;
                    if (addr == ADDR_MAX) begin
                        state_nxt = DONE;
                    end else begin
                        addr_adv  = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr          <= '0;
            stats_addr_q  <= '0;
            stats_count_q <= '0;
            entry_count   <= '0;
        end else begin
            if (sweep_start) begin
                addr        <= '0;
                entry_count <= '0;
            end else if (addr_adv) begin
                addr <= addr + 1'b1;
            end
            // Snapshot at the read edge so later meter updates cannot disturb a presented entry.
            if (read_fire) begin
                stats_addr_q  <= addr;
                stats_count_q <= bus.meter_read_data;
            end
            if (entry_taken) begin
                entry_count <= entry_count + 1'b1;
            end
        end
    end

    assign bus.meter_read_en     = read_fire;
    assign bus.meter_read_addr   = addr;
    assign bus.stats_valid       = (state == OUT);
    assign bus.stats_addr        = stats_addr_q;
    assign bus.stats_count       = stats_count_q;
    assign bus.stats_last        = (state == OUT) && (stats_addr_q == ADDR_MAX);
    assign bus.stats_busy        = (state != IDLE);
    assign bus.stats_done        = (state == DONE);
    assign bus.stats_entry_count = entry_count;

endmodule
